// File: rtl/result_bcd_display_if.sv
// Handshake bundle between the multiplier and the result display stage.
// The master side supplies the product and a start request; the slave side
// reports conversion status and the latest BCD value.
interface result_bcd_display_if #(
    parameter int DATA_W = 6,
    parameter int DIGITS = 4
) ();

    logic [DATA_W-1:0]   Data;
    logic                Start;
    logic                Busy;
    logic                Ready;
    logic [4*DIGITS-1:0] Bcd;

    modport master (
        output Data,
        output Start,
        input  Busy,
        input  Ready,
        input  Bcd
    );

    modport slave (
        input  Data,
        input  Start,
        output Busy,
        output Ready,
        output Bcd
    );

endinterface

// File: rtl/result_bcd_display.sv
// Result display stage of the shift-add multiplier datapath.
// Captures the product, converts it to BCD with a sequential double-dabble
// (one shift per clock), and scans the digits onto a common-anode 7-segment
// display with active-low segments and anodes.
// Optional feature: define BLANK_LEADING_ZERO_EN to blank leading zero digits
// (digit 0 is never blanked, so zero still shows as a single "0").
module result_bcd_display #(
    parameter int DATA_W      = 6,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    result_bcd_display_if.slave   link,
    output logic [6:0]            Seg,
    output logic [DIGITS-1:0]     An
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   bin;
    logic [DATA_W-1:0]   bin_next;
    logic [BCD_W-1:0]    work;
    logic [BCD_W-1:0]    work_next;
    logic [BCD_W-1:0]    work_adj;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_next;
    logic                busy;
    logic                busy_next;
    logic                ready;
    logic                ready_next;

    logic [REF_W-1:0]    refresh_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic [3:0]          cur_digit;
    logic                blank_digit;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;
    logic [DIGITS-1:0]   lead_zero;

    // Active-low gfedcba pattern for one BCD code; non-decimal codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Add-3 correction on every work digit that would overflow on the next shift.
    always_comb begin
        work_adj = work;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[4*d +: 4] >= 4'd5) begin
                work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM next-state and datapath next values.
    always_comb begin
        state_next = state;
        bin_next   = bin;
        work_next  = work;
        cnt_next   = cnt;
        bcd_next   = bcd;
        busy_next  = busy;
        ready_next = 1'b0;
        case (state)
            IDLE: begin
                if (link.Start) begin
                    bin_next   = link.Data;
                    work_next  = '0;
                    cnt_next   = CNT_W'(DATA_W);
                    busy_next  = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                work_next = (work_adj << 1) | BCD_W'(bin[DATA_W-1]);
                bin_next  = bin << 1;
                cnt_next  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_next   = work;
                ready_next = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Conversion FSM state and datapath registers; reset aborts any conversion.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            bin   <= '0;
            work  <= '0;
            cnt   <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            bin   <= bin_next;
            work  <= work_next;
            cnt   <= cnt_next;
            bcd   <= bcd_next;
            busy  <= busy_next;
            ready <= ready_next;
        end
    end

    assign link.Busy  = busy;
    assign link.Ready = ready;
    assign link.Bcd   = bcd;

    // Refresh divider and digit scan index, free-running independent of the FSM.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            if (scan_idx == IDX_W'(DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

    // Mark digits that sit above the most significant nonzero digit.
    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        lead_zero  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above_zero   = above_zero & (bcd[4*i +: 4] == 4'd0);
            lead_zero[i] = above_zero;
        end
        lead_zero[0] = 1'b0;
    end

    // Select the scanned digit and build the next segment and anode patterns.
    always_comb begin
        cur_digit   = 4'd0;
        blank_digit = 1'b0;
        an_next     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_digit   = bcd[4*i +: 4];
                blank_digit = lead_zero[i];
                an_next[i]  = 1'b0;
            end
        end
`ifdef BLANK_LEADING_ZERO_EN
        seg_next = blank_digit ? 7'b1111111 : seg_decode(cur_digit);
`else
        seg_next = seg_decode(cur_digit);
`endif
    end

    // Registered display drive; reset shows "0" on digit 0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Seg <= 7'b1000000;
            An  <= ~DIGITS'(1);
        end else begin
            Seg <= seg_next;
            An  <= an_next;
        end
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed self-checking bench for result_bcd_display (REFRESH_DIV=4).
// Define BLANK_LEADING_ZERO_EN to also exercise leading-zero blanking.
module tb_result_bcd_display;

    logic       Clock;
    logic       Reset;
    logic [6:0] Seg;
    logic [3:0] An;

    int checks = 0;
    int errors = 0;

    result_bcd_display_if #(.DATA_W(6), .DIGITS(4)) link ();

    result_bcd_display #(
        .DATA_W(6),
        .DIGITS(4),
        .REFRESH_DIV(4)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .link  (link),
        .Seg   (Seg),
        .An    (An)
    );

    // Free-running 10 ns clock.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Hard stop in case something unexpectedly stalls the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Present a value and hold Start for exactly one sampling edge.
    task automatic applyStimulus(input logic [5:0] value);
        link.Data  = value;
        link.Start = 1'b1;
        tick();
        link.Start = 1'b0;
    endtask

    // Wait (bounded) for the Ready pulse, then check latency and result.
    task automatic waitReady(input string tag, input logic [15:0] expected_bcd);
        int cycles;
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            cycles++;
            if (link.Ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_latency"}, cycles, 32'd7);
            checkOutput({tag, "_bcd"}, link.Bcd, expected_bcd);
        end
    endtask

    // Align to the start of digit 0's slot, then check one full scan round.
    task automatic observeScan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] seg_pat [4];
        logic [3:0] an_pat [4];
        logic [3:0] prev;
        bit found;
        seg_pat[0] = s0;
        seg_pat[1] = s1;
        seg_pat[2] = s2;
        seg_pat[3] = s3;
        an_pat[0]  = 4'b1110;
        an_pat[1]  = 4'b1101;
        an_pat[2]  = 4'b1011;
        an_pat[3]  = 4'b0111;
        tick();
        prev  = An;
        found = 1'b0;
        for (int k = 0; k < 24 && !found; k++) begin
            tick();
            if (An == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = An;
        end
        if (!found) begin
            checkOutput({tag, "_align_timeout"}, 32'd0, 32'd1);
        end else begin
            for (int c = 0; c < 16; c++) begin
                checkOutput({tag, "_an"}, An, an_pat[c / 4]);
                checkOutput({tag, "_seg"}, Seg, seg_pat[c / 4]);
                if (c < 15) tick();
            end
        end
    endtask

    initial begin
        int pulses;
        Reset      = 1'b1;
        link.Data  = '0;
        link.Start = 1'b0;

        // Test 1: reset for two cycles then release
        tick();
        tick();
        Reset = 1'b0;
        checkOutput("rst_bcd", link.Bcd, 16'h0000);
        checkOutput("rst_busy", link.Busy, 1'b0);
        checkOutput("rst_ready", link.Ready, 1'b0);
        checkOutput("rst_an", An, 4'b1110);
        checkOutput("rst_seg", Seg, 7'b1000000);
        tick();
        checkOutput("rel_an", An, 4'b1110);
        checkOutput("rel_seg", Seg, 7'b1000000);

        // Test 2: Data=63, exact Busy/Ready timing
        applyStimulus(6'd63);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("t2_busy", link.Busy, 1'b1);
            checkOutput("t2_ready_early", link.Ready, 1'b0);
        end
        tick();
        checkOutput("t2_ready", link.Ready, 1'b1);
        checkOutput("t2_busy_done", link.Busy, 1'b0);
        checkOutput("t2_bcd", link.Bcd, 16'h0063);
        tick();
        checkOutput("t2_ready_pulse", link.Ready, 1'b0);
        checkOutput("t2_bcd_hold", link.Bcd, 16'h0063);

        // Test 3: second Start during conversion is ignored
        applyStimulus(6'd36);
        tick();
        tick();
        link.Data  = 6'd9;
        link.Start = 1'b1;
        tick();
        link.Start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (link.Ready === 1'b1) pulses++;
        end
        checkOutput("t3_pulses", pulses, 32'd1);
        checkOutput("t3_bcd", link.Bcd, 16'h0036);

        // Test 4: reset in the middle of a conversion
        applyStimulus(6'd45);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("t4_busy", link.Busy, 1'b0);
        checkOutput("t4_bcd", link.Bcd, 16'h0000);
        checkOutput("t4_ready", link.Ready, 1'b0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (link.Ready === 1'b1) pulses++;
        end
        checkOutput("t4_no_ready", pulses, 32'd0);
        checkOutput("t4_bcd_still", link.Bcd, 16'h0000);
        applyStimulus(6'd7);
        waitReady("t4_restart", 16'h0007);

        // Test 5: display scan of 63
        applyStimulus(6'd63);
        waitReady("t5_conv", 16'h0063);
`ifdef BLANK_LEADING_ZERO_EN
        observeScan("t5_scan", 7'b0110000, 7'b0000010, 7'b1111111, 7'b1111111);
`else
        observeScan("t5_scan", 7'b0110000, 7'b0000010, 7'b1000000, 7'b1000000);
`endif

`ifdef BLANK_LEADING_ZERO_EN
        // Test 6a: leading-zero blanking with a single digit
        applyStimulus(6'd9);
        waitReady("t6_conv9", 16'h0009);
        observeScan("t6_scan9", 7'b0010000, 7'b1111111, 7'b1111111, 7'b1111111);
`endif

        // Data=0 still takes the full shift count and yields zero
        applyStimulus(6'd0);
        waitReady("t6_conv0", 16'h0000);
`ifdef BLANK_LEADING_ZERO_EN
        observeScan("t6_scan0", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
`else
        observeScan("t6_scan0", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
